// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam word_t PC_INC           = 16'd2;
    localparam word_t DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - held-request instruction memory port
interface fetch_if;
    import fetch_pkg::*;

    logic  req;
    word_t addr;
    logic  ready;
    word_t data;

    modport master (output req, addr, input ready, data);
    modport slave  (input req, addr, output ready, data);
endinterface

// File: rtl/cla_16.sv
// rtl/cla_16.sv - 16-bit adder, 4-bit groups with lookahead between groups
module cla_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic        sat,
    output logic [15:0] sum
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  blk_c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        blk_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            blk_c[k+1] = grp_g[k] | (grp_p[k] & blk_c[k]);
        end
        c = '0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) c[i] = blk_c[i/4];
            else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        sum = (sat && blk_c[4]) ? 16'hFFFF : (p ^ c);
    end
endmodule

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry {instr, pc} buffer behind the fetch output register
module fetch_skid
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_pc,
    output logic  valid,
    output word_t instr,
    output word_t pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, held memory requests, output/skid, redirect and halt
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
)(
    input  logic     clk,
    input  logic     rst,
    input  logic     stall,
    input  logic     redirect,
    input  word_t    redirect_pc,
    input  logic     hlt,
    fetch_if.master  imem,
    output logic     if_valid,
    output word_t    if_instr,
    output word_t    if_pc,
    output word_t    pc,
    output logic     halted
);
    fetch_state_t state, state_n;
    word_t pc_n, pc_plus, fetch_addr, fetch_addr_n;
    logic  halt_pend, halt_pend_n;
    logic  out_valid_n;
    word_t out_instr_n, out_pc_n;
    logic  skid_load, skid_drain, skid_clear, skid_valid;
    word_t skid_instr, skid_pc;
    logic  resp;

    // fetch_addr tracks pc except in DROP, where it keeps the abandoned request's address
    assign imem.req  = (state == FETCH && !skid_valid) || state == DROP;
    assign imem.addr = fetch_addr;
    assign resp      = imem.req && imem.ready;
    assign halted    = (state == HALT);

    cla_16 u_pc_inc (.a(pc), .b(PC_INC), .cin(1'b0), .sat(1'b0), .sum(pc_plus));

    fetch_skid u_skid (
        .clk(clk), .rst(rst), .load(skid_load), .drain(skid_drain), .clear(skid_clear),
        .load_instr(imem.data), .load_pc(fetch_addr),
        .valid(skid_valid), .instr(skid_instr), .pc(skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        fetch_addr_n = fetch_addr;
        halt_pend_n  = halt_pend;
        out_valid_n  = if_valid;
        out_instr_n  = if_instr;
        out_pc_n     = if_pc;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;
        if (!stall) out_valid_n = 1'b0;
        case (state)
            IDLE: begin
                state_n = FETCH;
                if (redirect) begin
                    pc_n         = redirect_pc;
                    fetch_addr_n = redirect_pc;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_n        = redirect_pc;
                    out_valid_n = 1'b0;
                    skid_clear  = 1'b1;
                    if (imem.req && !imem.ready) state_n = DROP;
                    else                         fetch_addr_n = redirect_pc;
                end else if (hlt && !stall) begin
                    out_valid_n = 1'b0;
                    skid_clear  = 1'b1;
                    if (imem.req && !imem.ready) begin
                        state_n     = DROP;
                        halt_pend_n = 1'b1;
                    end else begin
                        state_n = HALT;
                    end
                end else if (!stall && skid_valid) begin
                    out_valid_n = 1'b1;
                    out_instr_n = skid_instr;
                    out_pc_n    = skid_pc;
                    skid_drain  = 1'b1;
                end else if (resp) begin
                    pc_n         = pc_plus;
                    fetch_addr_n = pc_plus;
                    if (!if_valid || !stall) begin
                        out_valid_n = 1'b1;
                        out_instr_n = imem.data;
                        out_pc_n    = fetch_addr;
                    end else begin
                        skid_load = 1'b1;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_n        = redirect_pc;
                    out_valid_n = 1'b0;
                end
                if (resp) begin
                    state_n      = halt_pend ? HALT : FETCH;
                    fetch_addr_n = pc_n;
                end
            end
            HALT:    out_valid_n = 1'b0;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            halt_pend  <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            pc         <= pc_n;
            fetch_addr <= fetch_addr_n;
            halt_pend  <= halt_pend_n;
            if_valid   <= out_valid_n;
            if_instr   <= out_instr_n;
            if_pc      <= out_pc_n;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against an instruction-stream model
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, hlt;
    logic [15:0] redirect_pc;
    logic        if_valid, halted;
    logic [15:0] if_instr, if_pc, pc;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;
    int wait_cnt = 0;

    fetch_if imem ();

    fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .hlt(hlt), .imem(imem),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Memory: ready arrives in the lat-th cycle of a held request
    assign imem.ready = imem.req && (wait_cnt >= lat - 1);
    assign imem.data  = imem.ready ? mem_word(imem.addr) : 16'h0000;

    always @(posedge clk) begin
        if (!imem.req || imem.ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream model: decode sees consecutive even addresses, restarting at every redirect target
    logic [15:0] exp_pc, hold_pc, prev_addr;
    logic        hold_chk, prev_pend;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc    = 16'h0000;
            hold_chk  = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (hold_chk)
                check_eq("stall_hold", {15'b0, if_valid, if_pc}, {15'b0, 1'b1, hold_pc});
            if (prev_pend)
                check_eq("req_held", {15'b0, imem.req, imem.addr}, {15'b0, 1'b1, prev_addr});
            hold_chk  = stall && !redirect && if_valid;
            hold_pc   = if_pc;
            prev_pend = imem.req && !imem.ready;
            prev_addr = imem.addr;
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (if_valid && !stall) begin
                check_eq("stream_pc", 32'(if_pc), 32'(exp_pc));
                check_eq("stream_instr", 32'(if_instr), 32'(mem_word(exp_pc)));
                exp_pc = exp_pc + 16'd2;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] r16;
        logic [15:0] pc_frozen;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; hlt = 1'b0; lat = 1;
        step(); step();
        check_eq("rst_out", {if_valid, halted, imem.req}, 32'h0);
        check_eq("rst_regs", {pc, if_pc}, 32'h0);
        check_eq("rst_instr", 32'(if_instr), 32'h0);

        // zero-wait memory: one instruction per cycle from cycle 2
        rst = 1'b0;
        check_eq("c0_req", 32'(imem.req), 32'h0);
        step();
        check_eq("c1_req", {15'b0, imem.req, imem.addr}, {15'b0, 1'b1, 16'h0000});
        step();
        check_eq("c2_out", {15'b0, if_valid, if_pc}, {15'b0, 1'b1, 16'h0000});
        check_eq("c2_pc", 32'(pc), 32'h2);
        for (int i = 1; i < 4; i++) begin
            step();
            check_eq("seq_pc", {15'b0, if_valid, if_pc}, {15'b0, 1'b1, 16'(2 * i)});
        end

        // 3-cycle memory, 4-cycle stall with full output
        rst = 1'b1; lat = 3;
        step();
        rst = 1'b0;
        n = 0;
        while (!if_valid && n < 20) begin step(); n++; end
        check_eq("wait_first", 32'(n < 20), 32'h1);
        stall = 1'b1;
        step(); step(); step();
        check_eq("skid_req_drop", 32'(imem.req), 32'h0);
        check_eq("skid_out_hold", 32'(if_pc), 32'h0);
        step();
        stall = 1'b0;
        check_eq("stall_last", 32'(if_pc), 32'h0);
        step();
        check_eq("skid_out", {15'b0, if_valid, if_pc}, {15'b0, 1'b1, 16'h0002});
        check_eq("skid_instr", 32'(if_instr), 32'hA002);
        check_eq("after_skid_addr", {15'b0, imem.req, imem.addr}, {15'b0, 1'b1, 16'h0004});

        // redirect while the request to 0x0008 is pending
        n = 0;
        while (!(imem.req && imem.addr == 16'h0008 && !imem.ready) && n < 30) begin step(); n++; end
        check_eq("wait_req8", 32'(n < 30), 32'h1);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        check_eq("drop_hold", {15'b0, imem.req, imem.addr}, {15'b0, 1'b1, 16'h0008});
        n = 0;
        while (imem.req && imem.addr == 16'h0008 && n < 10) begin
            check_eq("drop_no_valid", 32'(if_valid), 32'h0);
            step(); n++;
        end
        check_eq("drop_target", {15'b0, imem.req, imem.addr}, {15'b0, 1'b1, 16'h0100});
        n = 0;
        while (!if_valid && n < 10) begin step(); n++; end
        check_eq("target_out", {15'b0, if_valid, if_pc}, {15'b0, 1'b1, 16'h0100});
        check_eq("target_instr", 32'(if_instr), 32'hA100);

        // redirect + stall together with a full skid
        stall = 1'b1;
        n = 0;
        while (imem.req && n < 10) begin step(); n++; end
        check_eq("skid_full", 32'(imem.req), 32'h0);
        redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect = 1'b0; stall = 1'b0;
        check_eq("flush_out", 32'(if_valid), 32'h0);
        check_eq("flush_req", {15'b0, imem.req, imem.addr}, {15'b0, 1'b1, 16'h0200});
        n = 0;
        while (!if_valid && n < 10) begin step(); n++; end
        check_eq("flush_target", {15'b0, if_valid, if_pc}, {15'b0, 1'b1, 16'h0200});

        // pc wrap-around with zero-wait memory
        lat = 1;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        check_eq("wrap_addr0", 32'(imem.addr), 32'hFFFE);
        step();
        check_eq("wrap_addr1", 32'(imem.addr), 32'h0000);
        check_eq("wrap_pc", {pc, if_pc}, {16'h0000, 16'hFFFE});

        // randomized latency, stalls and redirects
        for (int i = 0; i < 500; i++) begin
            stall    = ($urandom % 100) < 30;
            redirect = ($urandom % 100) < 5;
            r16 = 16'($urandom);
            redirect_pc = r16 & 16'hFFFE;
            if (($urandom % 8) == 0) lat = 1 + int'($urandom % 4);
            step();
        end
        stall = 1'b0; redirect = 1'b0;

        // hlt with a pending 2-cycle request
        lat = 2;
        n = 0;
        while (!(if_valid && imem.req && !imem.ready) && n < 40) begin step(); n++; end
        check_eq("wait_hlt", 32'(n < 40), 32'h1);
        hlt = 1'b1;
        pc_frozen = pc;
        step();
        hlt = 1'b0;
        check_eq("hlt_drain", {imem.req, halted, if_valid}, 32'h4);
        n = 0;
        while (!halted && n < 10) begin step(); n++; end
        check_eq("halted", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            check_eq("halt_idle", {13'b0, imem.req, if_valid, halted, pc},
                     {13'b0, 1'b0, 1'b0, 1'b1, pc_frozen});
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
